// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the fetch PC sequencer: redirect source ranks and controller states.
// Source encoding is ordered so a plain magnitude compare gives redirect priority.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_TRAP   = 2'd3
  } redir_src_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_ctrl_state_t;

  // Branch and trap redirects squash the instruction already decoded; a jump resolved in ID does not.
  function automatic logic flushes_idex(input redir_src_t src);
    return (src == SRC_BRANCH) || (src == SRC_TRAP);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Signal bundle between the core (hazard unit, imem, EX/ID resolvers, PC register) and pc_redirect_ctrl.
// Trap request/vector exist only when PC_TRAP_EN is defined.
interface pc_redirect_ctrl_if;
  logic        hazard_stall;
  logic        imem_busy;
  logic        ex_branch_taken;
  logic [31:0] ex_target;
  logic        id_jump;
  logic [31:0] id_target;
`ifdef PC_TRAP_EN
  logic        trap_req;
  logic [31:0] trap_vec;
`endif
  logic        pc_enable;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush_ifid;
  logic        flush_idex;
  logic        fetch_kill;
  logic        redirect_pending;

  modport master (
`ifdef PC_TRAP_EN
    output trap_req, trap_vec,
`endif
    output hazard_stall, imem_busy, ex_branch_taken, ex_target, id_jump, id_target,
    input  pc_enable, pc_redirect, pc_target, flush_ifid, flush_idex, fetch_kill,
           redirect_pending
  );

  modport slave (
`ifdef PC_TRAP_EN
    input  trap_req, trap_vec,
`endif
    input  hazard_stall, imem_busy, ex_branch_taken, ex_target, id_jump, id_target,
    output pc_enable, pc_redirect, pc_target, flush_ifid, flush_idex, fetch_kill,
           redirect_pending
  );
endinterface

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Two-way redirect picker: the challenger wins only with a strictly higher rank, so ties keep the
// incumbent. Chained for the fresh-request pick and reused for latched-vs-fresh arbitration.
module redirect_prio_sel
  import cpu_ctrl_pkg::*;
(
  input  redir_src_t  inc_src,
  input  logic [31:0] inc_target,
  input  redir_src_t  chal_src,
  input  logic [31:0] chal_target,
  output redir_src_t  src,
  output logic [31:0] target
);
  logic take_chal;

  assign take_chal = chal_src > inc_src;
  assign src       = take_chal ? chal_src    : inc_src;
  assign target    = take_chal ? chal_target : inc_target;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: hold / step +4 / redirect, with latching of redirects that arrive mid-fetch.
// Define PC_TRAP_EN to add the trap source as the highest-rank redirect.
module pc_redirect_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  pc_redirect_ctrl_if.slave bus
);
  pc_ctrl_state_t state, state_d;
  redir_src_t     pend_src, pend_src_d;
  logic [31:0]    pend_target, pend_target_d;

  redir_src_t     jump_src, branch_src, trap_src, bj_src, new_src, win_src;
  logic [31:0]    trap_target, bj_target, new_target, win_target;

  // A jump seen under load-use stall is re-presented by ID once the stall clears.
  assign jump_src   = (bus.id_jump && !bus.hazard_stall) ? SRC_JUMP : SRC_NONE;
  assign branch_src = bus.ex_branch_taken ? SRC_BRANCH : SRC_NONE;
`ifdef PC_TRAP_EN
  assign trap_src    = bus.trap_req ? SRC_TRAP : SRC_NONE;
  assign trap_target = bus.trap_vec;
`else
  assign trap_src    = SRC_NONE;
  assign trap_target = '0;
`endif

  redirect_prio_sel u_sel_bj (
    .inc_src (branch_src), .inc_target (bus.ex_target),
    .chal_src(jump_src),   .chal_target(bus.id_target),
    .src     (bj_src),     .target     (bj_target)
  );

  redirect_prio_sel u_sel_new (
    .inc_src (trap_src), .inc_target (trap_target),
    .chal_src(bj_src),   .chal_target(bj_target),
    .src     (new_src),  .target     (new_target)
  );

  redirect_prio_sel u_sel_pend (
    .inc_src (pend_src), .inc_target (pend_target),
    .chal_src(new_src),  .chal_target(new_target),
    .src     (win_src),  .target     (win_target)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pend_src    <= SRC_NONE;
      pend_target <= '0;
    end else begin
      state       <= state_d;
      pend_src    <= pend_src_d;
      pend_target <= pend_target_d;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
  always_comb begin
    state_d              = state;
    pend_src_d           = pend_src;
    pend_target_d        = pend_target;
    bus.pc_enable        = 1'b0;
    bus.pc_redirect      = 1'b0;
    bus.pc_target        = '0;
    bus.flush_ifid       = 1'b0;
    bus.flush_idex       = 1'b0;
    bus.fetch_kill       = 1'b0;
    bus.redirect_pending = 1'b0;

    // Outputs are combinational, so reset must mask them as well as clear the registers.
    if (!rst) begin
      unique case (state)
        BOOT: begin
          if (!bus.imem_busy) begin
            bus.pc_enable   = 1'b1;
            bus.pc_redirect = 1'b1;
            bus.pc_target   = RESET_VECTOR;
            state_d         = RUN;
          end
        end
        RUN: begin
          if (new_src == SRC_NONE) begin
            bus.pc_enable = !(bus.hazard_stall || bus.imem_busy);
          end else if (!bus.imem_busy) begin
            bus.pc_enable   = 1'b1;
            bus.pc_redirect = 1'b1;
            bus.pc_target   = new_target;
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = flushes_idex(new_src);
          end else begin
            pend_src_d    = new_src;
            pend_target_d = new_target;
            state_d       = PEND;
          end
        end
        PEND: begin
          bus.redirect_pending = 1'b1;
          if (bus.imem_busy) begin
            pend_src_d    = win_src;
            pend_target_d = win_target;
          end else begin
            bus.fetch_kill  = 1'b1;
            bus.pc_enable   = 1'b1;
            bus.pc_redirect = 1'b1;
            bus.pc_target   = win_target;
            bus.flush_ifid  = 1'b1;
            bus.flush_idex  = flushes_idex(win_src);
            pend_src_d      = SRC_NONE;
            pend_target_d   = '0;
            state_d         = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed scenarios then random traffic, all checked
// against a rank/queue-level reference model. Honours PC_TRAP_EN.
module tb_pc_redirect_ctrl;
  localparam logic [31:0] RV = 32'h0000_1000;

  typedef struct packed {
    logic        en, redir, fi, fx, kill, pend, chk_tgt;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: booted flag and at most one latched redirect (rank 1 jump, 2 branch, 3 trap).
  bit          m_booted = 1'b0;
  bit          m_pend   = 1'b0;
  int          m_rank   = 0;
  logic [31:0] m_tgt    = '0;

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl #(.RESET_VECTOR(RV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge and queue the expected response.
  task automatic cycle(input bit r, input bit stall, input bit busy,
                       input bit br, input logic [31:0] bt,
                       input bit jmp, input logic [31:0] jt,
                       input bit trp, input logic [31:0] tv);
    exp_t        e;
    int          nr;
    logic [31:0] nt;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.hazard_stall    = stall;
    bus.imem_busy       = busy;
    bus.ex_branch_taken = br;
    bus.ex_target       = bt;
    bus.id_jump         = jmp;
    bus.id_target       = jt;
`ifdef PC_TRAP_EN
    bus.trap_req        = trp;
    bus.trap_vec        = tv;
`endif
    e  = '0;
    nr = 0;
    nt = '0;
    if (jmp && !stall) begin nr = 1; nt = jt; end
    if (br)            begin nr = 2; nt = bt; end
`ifdef PC_TRAP_EN
    if (trp)           begin nr = 3; nt = tv; end
`endif
    if (r) begin
      e.chk_tgt = 1'b1;
      m_booted  = 1'b0;
      m_pend    = 1'b0;
    end else if (!m_booted) begin
      if (!busy) begin
        e.en = 1'b1; e.redir = 1'b1; e.tgt = RV; e.chk_tgt = 1'b1;
        m_booted = 1'b1;
      end
    end else if (m_pend) begin
      e.pend = 1'b1;
      if (nr > m_rank) begin m_rank = nr; m_tgt = nt; end
      if (!busy) begin
        e.en = 1'b1; e.redir = 1'b1; e.tgt = m_tgt; e.chk_tgt = 1'b1;
        e.fi = 1'b1; e.fx = (m_rank >= 2); e.kill = 1'b1;
        m_pend = 1'b0;
      end
    end else if (nr > 0) begin
      if (busy) begin
        m_pend = 1'b1; m_rank = nr; m_tgt = nt;
      end else begin
        e.en = 1'b1; e.redir = 1'b1; e.tgt = nt; e.chk_tgt = 1'b1;
        e.fi = 1'b1; e.fx = (nr >= 2);
      end
    end else begin
      e.en = !(stall || busy);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit stall, input bit busy);
    cycle(1'b0, stall, busy, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: compare on the falling edge, midway between input updates.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_enable",        32'(bus.pc_enable),        32'(e.en));
        check("pc_redirect",      32'(bus.pc_redirect),      32'(e.redir));
        check("flush_ifid",       32'(bus.flush_ifid),       32'(e.fi));
        check("flush_idex",       32'(bus.flush_idex),       32'(e.fx));
        check("fetch_kill",       32'(bus.fetch_kill),       32'(e.kill));
        check("redirect_pending", 32'(bus.redirect_pending), 32'(e.pend));
        if (e.chk_tgt) check("pc_target", bus.pc_target, e.tgt);
      end
    end
  end

  initial begin
    bus.hazard_stall    = 1'b0;
    bus.imem_busy       = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_target       = '0;
    bus.id_jump         = 1'b0;
    bus.id_target       = '0;
`ifdef PC_TRAP_EN
    bus.trap_req        = 1'b0;
    bus.trap_vec        = '0;
`endif
    cycle(1'b1, 0, 0, 0, '0, 0, '0, 0, '0);
    cycle(1'b1, 0, 0, 0, '0, 0, '0, 0, '0);

    // Boot then step, with a busy cycle delaying boot first.
    idle(0, 1);
    repeat (3) idle(0, 0);
    idle(1, 0);

    // Taken branch overrides load-use stall.
    cycle(0, 1, 0, 1, 32'h40, 0, '0, 0, '0);

    // Jump latched across a 3-cycle fetch, applied on busy fall.
    cycle(0, 0, 1, 0, '0, 1, 32'h80, 0, '0);
    idle(0, 1);
    idle(0, 1);
    idle(0, 0);

    // Branch upgrades a latched jump; a later jump and a later branch are both dropped.
    cycle(0, 0, 1, 0, '0, 1, 32'h80, 0, '0);
    cycle(0, 0, 1, 1, 32'h100, 0, '0, 0, '0);
    cycle(0, 0, 1, 0, '0, 1, 32'h90, 0, '0);
    cycle(0, 0, 1, 1, 32'h180, 0, '0, 0, '0);
    idle(0, 0);

    // Jump under stall is ignored entirely.
    cycle(0, 1, 0, 0, '0, 1, 32'h300, 0, '0);

    // Trap against branch, zero-cycle and from the pending latch.
    cycle(0, 0, 0, 1, 32'h100, 0, '0, 1, 32'h200);
    cycle(0, 0, 1, 0, '0, 1, 32'h84, 0, '0);
    cycle(0, 0, 0, 1, 32'h104, 0, '0, 1, 32'h204);

    // Reset in PEND drops the stale target; boot uses the reset vector.
    cycle(0, 0, 1, 1, 32'h500, 0, '0, 0, '0);
    cycle(1, 0, 1, 0, '0, 0, '0, 0, '0);
    idle(0, 0);
    idle(0, 0);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) == 0),
            ($urandom_range(3) == 0),
            ($urandom_range(2) == 0),
            ($urandom_range(5) == 0), {$urandom_range(32'hFFFF), 2'b00},
            ($urandom_range(3) == 0), {$urandom_range(32'hFFFF), 2'b00},
            ($urandom_range(9) == 0), {$urandom_range(32'hFFFF), 2'b00});
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
